// File: rtl/n_to_binary_scanner_pkg.sv
// Shared definitions for the n-to-binary scanner: FSM state encoding and
// the index-width legality check used at elaboration.
package n_to_binary_scanner_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // True when binary_width bits can address every position of the vector
   function automatic bit binary_width_ok(input int input_width, input int binary_width);
      return (input_width >= 1) && (binary_width >= 1) && (binary_width < 32) &&
             ((64'd1 << binary_width) >= 64'(input_width));
   endfunction

endpackage

// File: rtl/n_to_binary_priority_encoder.sv
// Combinational priority encoder: index of the first set bit plus a found flag.
// Search direction flips to highest-first under N_TO_BINARY_SCANNER_MSB_FIRST_EN.
module n_to_binary_priority_encoder #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan in emission order; the first hit locks the index
   always_comb begin
      idx   = {IDX_W{1'b0}};
      found = 1'b0;
`ifdef N_TO_BINARY_SCANNER_MSB_FIRST_EN
      for (int i = WIDTH - 1; i >= 0; i--) begin
`else
      for (int i = 0; i < WIDTH; i++) begin
`endif
         if (vec[i] && !found) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end else begin
            idx   = idx;
            found = found;
         end
      end
   end

endmodule

// File: rtl/n_to_binary_scanner.sv
// Multi-hot to binary index scanner: accepts a vector, then emits one index
// per output handshake. Macro N_TO_BINARY_SCANNER_MSB_FIRST_EN selects highest-first order.
module n_to_binary_scanner
   import n_to_binary_scanner_pkg::*;
#(
   parameter int INPUT_WIDTH  = 8,
   parameter int BINARY_WIDTH = 3
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INPUT_WIDTH-1:0]  in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BINARY_WIDTH-1:0] out,
   output logic                    out_last,
   output logic                    in_zero
);

   generate
      if (!binary_width_ok(INPUT_WIDTH, BINARY_WIDTH)) begin : g_bad_width
         $error("n_to_binary_scanner: BINARY_WIDTH too small for INPUT_WIDTH");
      end
   endgenerate

   state_t                  state_r;
   state_t                  state_s;
   logic [INPUT_WIDTH-1:0]  residue_r;
   logic [INPUT_WIDTH-1:0]  residue_s;
   logic                    in_zero_r;
   logic                    in_zero_s;
   logic [BINARY_WIDTH-1:0] idx_s;
   logic                    found_s;
   logic [INPUT_WIDTH-1:0]  bit_s;
   logic                    single_s;
   logic                    out_hs_s;
   logic                    accept_s;
   logic                    in_ready_s;
   logic                    in_is_zero_s;

   n_to_binary_priority_encoder #(
      .WIDTH (INPUT_WIDTH),
      .IDX_W (BINARY_WIDTH)
   ) u_encoder (
      .vec   (residue_r),
      .idx   (idx_s),
      .found (found_s)
   );

   // The residue holds the presented bit too, so the outputs decode straight from registers
   assign bit_s        = INPUT_WIDTH'(1'b1) << idx_s;
   assign single_s     = found_s && ((residue_r & (residue_r - INPUT_WIDTH'(1'b1))) == {INPUT_WIDTH{1'b0}});
   assign out_hs_s     = (state_r == EMIT) && out_ready;
   assign in_ready_s   = (state_r == IDLE) || (out_hs_s && single_s);
   assign accept_s     = in_valid && in_ready_s;
   assign in_is_zero_s = (in == {INPUT_WIDTH{1'b0}});

   assign in_ready  = in_ready_s;
   assign out_valid = (state_r == EMIT);
   assign out       = idx_s;
   assign out_last  = single_s;
   assign in_zero   = in_zero_r;

   // Next-state and residue update
   always_comb begin
      state_s   = state_r;
      residue_s = residue_r;
      in_zero_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               residue_s = in;
               in_zero_s = in_is_zero_s;
               state_s   = in_is_zero_s ? IDLE : EMIT;
            end else begin
               state_s   = IDLE;
            end
         end
         EMIT: begin
            if (accept_s) begin
               residue_s = in;
               in_zero_s = in_is_zero_s;
               state_s   = in_is_zero_s ? IDLE : EMIT;
            end else if (out_hs_s) begin
               residue_s = residue_r & ~bit_s;
               state_s   = single_s ? IDLE : EMIT;
            end else begin
               state_s   = EMIT;
            end
         end
         default: begin
            state_s   = IDLE;
            residue_s = {INPUT_WIDTH{1'b0}};
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         residue_r <= {INPUT_WIDTH{1'b0}};
         in_zero_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         residue_r <= residue_s;
         in_zero_r <= in_zero_s;
      end
   end

endmodule

// File: tb/tb_n_to_binary_scanner.sv
// Self-checking bench for n_to_binary_scanner: directed cycle tables plus
// randomized traffic against a queue-based reference model.
module tb_n_to_binary_scanner;

   localparam int IW = 8;
   localparam int BW = 3;

`ifdef N_TO_BINARY_SCANNER_MSB_FIRST_EN
   localparam int F029[3] = '{5, 2, 0};
   localparam int F030[2] = '{7, 0};
   localparam int F033[2] = '{7, 6};
`else
   localparam int F029[3] = '{0, 2, 5};
   localparam int F030[2] = '{0, 7};
   localparam int F033[2] = '{0, 1};
`endif

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out;
   logic          out_last;
   logic          in_zero;

   int checks   = 0;
   int failures = 0;

   typedef int iq_t[$];
   iq_t  pend;
   logic zero_exp = 1'b0;

   typedef struct {
      logic          rst_n;
      logic          iv;
      logic [IW-1:0] vin;
      logic          ordy;
      logic          eov;
      logic [BW-1:0] eout;
      logic          elast;
      logic          erdy;
      logic          ezero;
   } row_t;

   row_t tbl[$];

   always #5 clock = ~clock;

   n_to_binary_scanner #(
      .INPUT_WIDTH  (IW),
      .BINARY_WIDTH (BW)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_last  (out_last),
      .in_zero   (in_zero)
   );

   function automatic row_t mk(input logic r, input logic iv, input logic [IW-1:0] v,
                               input logic ordy, input logic eov, input logic [BW-1:0] eout,
                               input logic elast, input logic erdy, input logic ezero);
      row_t t;
      t.rst_n = r;    t.iv = iv;       t.vin = v;       t.ordy = ordy;
      t.eov   = eov;  t.eout = eout;   t.elast = elast; t.erdy = erdy; t.ezero = ezero;
      return t;
   endfunction

   // Set-bit positions in emission order
   function automatic iq_t indices(input logic [IW-1:0] v);
      iq_t q;
      for (int i = 0; i < IW; i++) begin
         if (v[i]) begin
`ifdef N_TO_BINARY_SCANNER_MSB_FIRST_EN
            q.push_front(i);
`else
            q.push_back(i);
`endif
         end
      end
      return q;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs shortly after the rising edge; outputs are settled when it returns
   task automatic drive(input logic r, input logic iv, input logic [IW-1:0] v, input logic ordy);
      @(posedge clock);
      #1;
      reset_n   = r;
      in_valid  = iv;
      in        = v;
      out_ready = ordy;
      #1;
   endtask

   // Advance the reference model across the coming edge using the current inputs
   task automatic model_edge();
      bit rdy;
      bit hs;
      bit acc;
      if (!reset_n) begin
         pend.delete();
         zero_exp = 1'b0;
      end else begin
         rdy = (pend.size() == 0) || (out_ready && pend.size() == 1);
         hs  = (pend.size() > 0) && out_ready;
         acc = in_valid && rdy;
         if (hs) void'(pend.pop_front());
         zero_exp = acc && (in == '0);
         if (acc) pend = indices(in);
      end
   endtask

   task automatic check_model(input string tag);
      bit eov;
      eov = pend.size() > 0;
      chk({tag, "_ov"}, 32'(out_valid), 32'(eov));
      if (eov) chk({tag, "_out"}, 32'(out), 32'(pend[0]));
      chk({tag, "_last"}, 32'(out_last), 32'(pend.size() == 1));
      chk({tag, "_rdy"}, 32'(in_ready), 32'((pend.size() == 0) || (out_ready && pend.size() == 1)));
      chk({tag, "_zero"}, 32'(in_zero), 32'(zero_exp));
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b0;

      // Directed scenarios: lowest/highest-first order, stall, back-to-back, zero, mid-emission reset
      tbl.push_back(mk(1'b1, 1'b1, 8'h25, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'(F029[0]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'(F029[1]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'(F029[2]), 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'(F030[0]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 3'(F030[0]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'(F030[0]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'(F030[0]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'(F030[1]), 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'(F033[0]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'(F033[1]), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));

      // Reset with a vector offered: it must be ignored
      drive(1'b0, 1'b1, 8'hFF, 1'b1);
      drive(1'b0, 1'b1, 8'hFF, 1'b1);
      model_edge();
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      chk("rst_ov",   32'(out_valid), 32'd0);
      chk("rst_out",  32'(out),       32'd0);
      chk("rst_last", 32'(out_last),  32'd0);
      chk("rst_zero", 32'(in_zero),   32'd0);
      chk("rst_rdy",  32'(in_ready),  32'd1);
      model_edge();

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].iv, tbl[i].vin, tbl[i].ordy);
         chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].eov));
         if (tbl[i].eov) chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].eout));
         chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].elast));
         chk($sformatf("tbl%0d_rdy", i),  32'(in_ready), 32'(tbl[i].erdy));
         chk($sformatf("tbl%0d_zero", i), 32'(in_zero),  32'(tbl[i].ezero));
         model_edge();
      end

      // Random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         logic          r;
         logic          iv;
         logic          ordy;
         logic [IW-1:0] v;
         r    = ($urandom_range(0, 99) != 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       v = 8'h00;
            1:       v = 8'(1 << $urandom_range(0, 7));
            default: v = 8'($urandom);
         endcase
         drive(r, iv, v, ordy);
         check_model($sformatf("rnd%0d", c));
         model_edge();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/n_to_binary_scanner.md
N_TO_BINARY_SCANNER -- requirements
Module: n_to_binary_scanner

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8: width of the accepted bit vector; must be 1 or more.
REQ-002 SHALL have parameter BINARY_WIDTH, default 3: width of the emitted index; 2^BINARY_WIDTH >= INPUT_WIDTH, else elaboration error.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: upstream vector is valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-007 SHALL have port in, input, INPUT_WIDTH: multi-hot vector to convert.
REQ-008 SHALL have port out_valid, output, 1: out holds a valid index.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts index.
REQ-010 SHALL have port out, output, BINARY_WIDTH: binary index of one set bit.
REQ-011 SHALL have port out_last, output, 1: current index is the final set bit of the vector.
REQ-012 SHALL have port in_zero, output, 1: one-cycle pulse when an all-zero vector is accepted.

Function
REQ-013 SHALL implement two states: IDLE (no pending bits) and EMIT (pending bits held in a residue register).
REQ-014 SHALL assert in_ready in IDLE, and in EMIT only in a cycle where out_valid, out_ready and out_last are all high.
REQ-015 SHALL accept a vector when in_valid and in_ready are both high; the accepted vector loads the residue register.
REQ-016 SHALL present the first index on out, with out_valid high, in the cycle after acceptance. Latency is 1 cycle. The output is registered.
REQ-017 SHALL emit indices lowest-first by default, one per out handshake. Each handshake clears that bit from the residue.
REQ-018 SHALL hold out, out_valid and out_last stable while out_valid is high and out_ready is low.
REQ-019 SHALL assert out_last exactly when the residue contains a single set bit.
REQ-020 SHALL go from EMIT to IDLE on the last handshake when no new vector is accepted in that cycle. If a new non-zero vector is accepted in that cycle, it SHALL stay in EMIT and present the new vector's first index the next cycle, giving full throughput.
REQ-021 SHALL handle an all-zero vector as follows: no output, in_zero pulses the next cycle, and the block stays in or returns to IDLE.
REQ-022 SHALL have the upper BINARY_WIDTH index values beyond INPUT_WIDTH-1 never emitted.
REQ-023 SHALL ignore in_valid while in_ready is low; in has no effect then.

Reset
REQ-024 SHALL, on reset_n low at a clock edge, drive state to IDLE, residue to 0, out to 0, out_valid to 0, out_last to 0 and in_zero to 0; in_ready SHALL be 1 the first cycle after reset.
REQ-025 SHALL discard any pending residue when reset occurs mid-emission; no further indices of that vector are emitted.

Configuration
REQ-026 SHALL, when macro N_TO_BINARY_SCANNER_MSB_FIRST_EN is defined, emit indices highest-first, with out_last still marking the final emitted bit; when it is undefined, order is lowest-first.

Structure
REQ-027 SHALL place the state encodings (IDLE, EMIT) and the BINARY_WIDTH legality check function in the shared addressing package/include.
REQ-028 SHALL instantiate one combinational sub-module, n_to_binary_priority_encoder (vector in, index plus found flag out), applied to the residue register.

Verification
REQ-029 SHALL cover this scenario: accept in=8'b0010_0101 -> out=0,2,5 on consecutive cycles with out_ready=1; out_last only with 5.
REQ-030 SHALL cover this scenario: in=8'b1000_0001 with out_ready low for 3 cycles after first index -> out stays 0, out_valid stays high; then 7 with out_last.
REQ-031 SHALL cover this scenario: back-to-back: 8'b0000_0010 then 8'b0000_1000 offered continuously -> out=1 (last), then 3 (last) the next cycle, no bubble.
REQ-032 SHALL cover this scenario: in=8'h00 accepted -> in_zero pulses one cycle, out_valid stays 0, in_ready stays 1.
REQ-033 SHALL cover this scenario: in=8'hFF, reset_n low after second index -> the next cycle has out_valid=0 and in_ready=1; indices 2..7 are never emitted.
REQ-034 SHALL cover this scenario: with N_TO_BINARY_SCANNER_MSB_FIRST_EN, in=8'b0010_0101 -> out=5,2,0; out_last with 0.
